// File: rtl/fuzz_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fuzz_seq_pkg
//  Purpose  : Shared constants, state encoding and helper functions for the
//             fuzz stimulus sequencer (LCG, MISR polynomial, word counting).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fuzz_seq_pkg;

    localparam logic [31:0] LCG_MUL   = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC   = 32'h0000_3039;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        FILL  = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // One LCG step; the product is kept modulo 2^32.
    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        return x * LCG_MUL + LCG_INC;
    endfunction

    // Number of 32-bit words needed to cover a vector of the given width.
    function automatic int nw_words(input int width);
        return (width + 31) / 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fuzz_stim_sequencer_misr.sv
`default_nettype none
// ============================================================================
//  Module   : resp_misr
//  Purpose  : Compacts a wide DUT response into a 32-bit MISR signature.
//             The response is split into 32-bit chunks (last chunk padded
//             with zeros), the chunks are XOR-folded, and the fold is
//             injected into a CRC-32 style shift register.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset (sig -> all ones)
//             i_clr   - reload sig with all ones
//             i_en    - absorb i_resp this cycle
//             i_resp  - DUT response vector, OUT_W bits
//             o_sig   - current signature
//  Revision : 1.0 - initial release
// ============================================================================
module resp_misr
    import fuzz_seq_pkg::*;
#(
    parameter int OUT_W = 330
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [OUT_W-1:0] i_resp,
    output logic [31:0]      o_sig
);

    localparam int NCH   = nw_words(OUT_W);
    localparam int PAD_W = NCH * 32;

    logic [PAD_W-1:0] w_pad;
    logic [31:0]      w_fold;
    logic [31:0]      r_sig;

    always_comb begin
        w_pad  = PAD_W'(i_resp);
        w_fold = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fold = w_fold ^ w_pad[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= 32'hFFFF_FFFF;
        end else if (i_clr) begin
            r_sig <= 32'hFFFF_FFFF;
        end else if (i_en) begin
            r_sig <= {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_fold;
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/fuzz_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fuzz_stim_sequencer
//  Purpose  : Drives one DUT through a reset phase and then single clock
//             steps. Before each step the DUT input vector is refilled one
//             32-bit word per clock from an LCG; during each step the DUT
//             response is folded into a MISR signature.
//  Ports    : clk          - clock (sequencer and gated DUT)
//             rst          - synchronous active-high reset
//             i_start      - launch pulse, honoured in IDLE or DONE
//             i_abort      - return to IDLE from RESET/FILL/STEP
//             i_seed       - LCG seed, captured on accepted start
//             i_cycles     - number of DUT steps, captured on accepted start
//             i_resp       - DUT flat output
//             o_stim       - DUT flat input (registered)
//             o_dut_rst_n  - DUT active-low reset (registered)
//             o_dut_ce     - DUT clock enable (registered)
//             o_busy       - high in RESET, FILL, STEP
//             o_done       - high in DONE
//             o_cyc_count  - completed step count
//             o_signature  - MISR state
//  Revision : 1.0 - initial release
// ============================================================================
module fuzz_stim_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int IN_W       = 271,
    parameter int OUT_W      = 330,
    parameter int RST_CYCLES = 2,
    parameter int CYC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [31:0]      i_seed,
    input  logic [CYC_W-1:0] i_cycles,
    input  logic [OUT_W-1:0] i_resp,
    output logic [IN_W-1:0]  o_stim,
    output logic             o_dut_rst_n,
    output logic             o_dut_ce,
    output logic             o_busy,
    output logic             o_done,
    output logic [CYC_W-1:0] o_cyc_count,
    output logic [31:0]      o_signature
);

    localparam int NW = nw_words(IN_W);
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);

    seq_state_e r_state;
    seq_state_e w_state_next;

    logic             w_accept;
    logic             w_fill;
    logic             w_step;
    logic [31:0]      w_lcg_next;
    logic [IN_W-1:0]  w_ins;
    logic [IN_W-1:0]  w_msk;
    logic [CYC_W-1:0] w_cyc_inc;

    logic [31:0]      r_lcg;
    logic [CYC_W-1:0] r_cycles;
    logic [CYC_W-1:0] r_cyc;
    logic [KW-1:0]    r_k;
    logic [RW-1:0]    r_rcnt;
    logic [IN_W-1:0]  r_stim;
    logic             r_dut_rst_n;
    logic             r_dut_ce;

    assign w_lcg_next = lcg_next(r_lcg);
    assign w_cyc_inc  = r_cyc + CYC_W'(1);

    // Word k lands at bit 32*k; shifting a zero-extended word into an
    // IN_W-bit vector drops whatever would fall above the top bit, which
    // is how the partial last word is trimmed.
    assign w_ins = IN_W'(w_lcg_next)   << {r_k, 5'b0};
    assign w_msk = IN_W'(32'hFFFF_FFFF) << {r_k, 5'b0};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_fill       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                // start beats a simultaneous abort here; abort is a no-op
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = RESET;
                end
            end
            RESET: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else if (r_rcnt == R_LAST) begin
                    w_state_next = (r_cycles == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_fill = 1'b1;
                    if (r_k == K_LAST) begin
                        w_state_next = STEP;
                    end
                end
            end
            STEP: begin
                if (i_abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_step       = 1'b1;
                    w_state_next = (w_cyc_inc == r_cycles) ? DONE : FILL;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: LCG, stim vector, counters, DUT controls
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcg       <= '0;
            r_cycles    <= '0;
            r_cyc       <= '0;
            r_k         <= '0;
            r_rcnt      <= '0;
            r_stim      <= '0;
            r_dut_rst_n <= 1'b0;
            r_dut_ce    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lcg    <= i_seed;
                r_cycles <= i_cycles;
                r_cyc    <= '0;
            end
            if (w_fill) begin
                r_lcg  <= w_lcg_next;
                r_stim <= (r_stim & ~w_msk) | w_ins;
            end
            if (w_step) begin
                r_cyc <= w_cyc_inc;
            end

            // Word index is zero whenever FILL is entered because it is
            // cleared on every cycle that is not a fill.
            r_k    <= (w_fill && (r_k != K_LAST)) ? r_k + KW'(1) : '0;
            r_rcnt <= ((r_state == RESET) && !i_abort) ? r_rcnt + RW'(1) : '0;

            // DUT controls track the state being entered so they are valid
            // for the whole of that state.
            r_dut_rst_n <= (w_state_next == FILL) || (w_state_next == STEP) ||
                           (w_state_next == DONE);
            r_dut_ce    <= (w_state_next == RESET) || (w_state_next == STEP);
        end
    end

    resp_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_step),
        .i_resp (i_resp),
        .o_sig  (o_signature)
    );

    assign o_stim      = r_stim;
    assign o_dut_rst_n = r_dut_rst_n;
    assign o_dut_ce    = r_dut_ce;
    assign o_cyc_count = r_cyc;
    assign o_busy      = (r_state == RESET) || (r_state == FILL) || (r_state == STEP);
    assign o_done      = (r_state == DONE);

endmodule
`default_nettype wire
